// File: rtl/axi_pkg.sv
// Shared AXI constants, FSM state types and the burst descriptor for the memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi_pkg;

  localparam int ID_W       = 4;
  localparam int AXI_ADDR_W = 32;

  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR,
    W_DATA,
    W_RESP
  } wr_state_t;

  // Burst descriptor latched at grant time and replayed on AR/AW.
  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
  } axi_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// N-way request arbiter, one-hot grant plus binary index; round-robin when AXI_ARB_RR_EN is
// defined (search starts at a pointer that moves to winner+1 on each taken grant), otherwise
// fixed priority with the lowest index winning. Latency: combinational grant. Backpressure: none.
// Ports: clock/reset (pointer only), req, advance (grant consumed this cycle), grant, grant_idx.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

`ifdef AXI_ARB_RR_EN

  logic [IDX_W-1:0] ptr;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // Walk offsets from the highest down so the smallest offset from ptr is the last writer.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    sum       = '0;
    cand      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (sum >= (IDX_W + 1)'(N)) begin
        sum = sum - (IDX_W + 1)'(N);
      end
      cand = sum[IDX_W-1:0];
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

`else

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
  end

  // Fixed priority keeps no state.
  logic unused_fixed;
  assign unused_fixed = ^{clock, reset, advance};

`endif

endmodule

// File: rtl/axi_mem_arbiter.sv
// Shares one AXI4 master port between N_RD read clients (one outstanding burst) and one
// write-back client. Latency: request to AR/AW valid 1 cycle; R and W beats pass through
// combinationally. Backpressure: AR/AW held until ready; io_rready/wr_wready follow the client/slave.
// Ports: rd_req_* / rd_r* read clients (packed per client), wr_req_* / wr_w* / wr_done write
// client, io_* AXI4 master. Optional macro AXI_ARB_RR_EN selects round-robin read arbitration.
module axi_mem_arbiter
  import axi_pkg::*;
#(
  parameter int N_RD   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  // read clients
  input  logic [N_RD-1:0]          rd_req_valid,
  output logic [N_RD-1:0]          rd_req_ready,
  input  logic [N_RD*ADDR_W-1:0]   rd_req_addr,
  input  logic [N_RD*8-1:0]        rd_req_len,
  input  logic [N_RD*3-1:0]        rd_req_size,
  output logic [N_RD-1:0]          rd_rvalid,
  output logic [N_RD-1:0]          rd_rlast,
  input  logic [N_RD-1:0]          rd_rready,
  output logic [DATA_W-1:0]        rd_rdata,
  // write-back client
  input  logic                     wr_req_valid,
  output logic                     wr_req_ready,
  input  logic [ADDR_W-1:0]        wr_req_addr,
  input  logic [7:0]               wr_req_len,
  input  logic [2:0]               wr_req_size,
  input  logic [DATA_W-1:0]        wr_wdata,
  input  logic [DATA_W/8-1:0]      wr_wstrb,
  input  logic                     wr_wvalid,
  output logic                     wr_wready,
  output logic                     wr_done,
  // AXI4 AR
  output logic [ADDR_W-1:0]        io_araddr,
  output logic [7:0]               io_arlen,
  output logic [2:0]               io_arsize,
  output logic [1:0]               io_arburst,
  output logic [ID_W-1:0]          io_arid,
  output logic                     io_arvalid,
  input  logic                     io_arready,
  // AXI4 R
  input  logic [DATA_W-1:0]        io_rdata,
  input  logic [1:0]               io_rresp,
  input  logic                     io_rlast,
  input  logic [ID_W-1:0]          io_rid,
  input  logic                     io_rvalid,
  output logic                     io_rready,
  // AXI4 AW
  output logic [ADDR_W-1:0]        io_awaddr,
  output logic [7:0]               io_awlen,
  output logic [2:0]               io_awsize,
  output logic [1:0]               io_awburst,
  output logic [ID_W-1:0]          io_awid,
  output logic                     io_awvalid,
  input  logic                     io_awready,
  // AXI4 W
  output logic [DATA_W-1:0]        io_wdata,
  output logic [DATA_W/8-1:0]      io_wstrb,
  output logic                     io_wlast,
  output logic                     io_wvalid,
  input  logic                     io_wready,
  // AXI4 B
  input  logic [1:0]               io_bresp,
  input  logic [ID_W-1:0]          io_bid,
  input  logic                     io_bvalid,
  output logic                     io_bready
);

  localparam int IDX_W = (N_RD > 1) ? $clog2(N_RD) : 1;

  // ---------------------------------------------------------------- read side
  rd_state_t        rd_state;
  logic [IDX_W-1:0] rd_idx;
  axi_req_t         ar_q;
  logic [ID_W-1:0]  ar_id_q;

  logic [N_RD-1:0]  arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_take;
  axi_req_t         rd_pick;

  assign arb_take = (rd_state == R_IDLE) && (|rd_req_valid);

  rr_arbiter #(
    .N     (N_RD),
    .IDX_W (IDX_W)
  ) u_rd_arb (
    .clock     (clock),
    .reset     (reset),
    .req       (rd_req_valid),
    .advance   (arb_take),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  always_comb begin
    rd_pick      = '0;
    rd_pick.addr = rd_req_addr[arb_idx*ADDR_W +: ADDR_W];
    rd_pick.len  = rd_req_len[arb_idx*8 +: 8];
    rd_pick.size = rd_req_size[arb_idx*3 +: 3];
  end

  // The AR payload is only reloaded in R_IDLE, so it stays stable while io_arvalid waits.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state <= R_IDLE;
      rd_idx   <= '0;
      ar_q     <= '0;
      ar_id_q  <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (arb_take) begin
            rd_idx   <= arb_idx;
            ar_q     <= rd_pick;
            ar_id_q  <= ID_W'(arb_idx);
            rd_state <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (io_arready) begin
            rd_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (io_rvalid && io_rready && io_rlast) begin
            rd_state <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  assign io_arvalid = (rd_state == R_ADDR);
  assign io_araddr  = ar_q.addr;
  assign io_arlen   = ar_q.len;
  assign io_arsize  = ar_q.size;
  assign io_arburst = BURST_INCR;
  assign io_arid    = ar_id_q;

  // Only the owning client sees the R channel; everyone else reads zeros.
  always_comb begin
    rd_req_ready = '0;
    rd_rvalid    = '0;
    rd_rlast     = '0;
    rd_rdata     = '0;
    io_rready    = 1'b0;
    if ((rd_state == R_ADDR) && io_arready) begin
      rd_req_ready[rd_idx] = 1'b1;
    end
    if (rd_state == R_DATA) begin
      rd_rvalid[rd_idx] = io_rvalid;
      rd_rlast[rd_idx]  = io_rvalid & io_rlast;
      rd_rdata          = io_rdata;
      io_rready         = rd_rready[rd_idx];
    end
  end

  // --------------------------------------------------------------- write side
  wr_state_t wr_state;
  axi_req_t  aw_q;
  logic [7:0] wcnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_state <= W_IDLE;
      aw_q     <= '0;
      wcnt     <= '0;
      wr_done  <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      case (wr_state)
        W_IDLE: begin
          if (wr_req_valid) begin
            aw_q.addr <= wr_req_addr;
            aw_q.len  <= wr_req_len;
            aw_q.size <= wr_req_size;
            wcnt      <= '0;
            wr_state  <= W_ADDR;
          end
        end
        W_ADDR: begin
          if (io_awready) begin
            wr_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (io_wvalid && io_wready) begin
            wcnt <= wcnt + 8'd1;
            if (io_wlast) begin
              wr_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (io_bvalid) begin
            wr_done  <= 1'b1;
            wr_state <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  assign wr_req_ready = (wr_state == W_IDLE);

  assign io_awvalid = (wr_state == W_ADDR);
  assign io_awaddr  = aw_q.addr;
  assign io_awlen   = aw_q.len;
  assign io_awsize  = aw_q.size;
  assign io_awburst = BURST_INCR;
  assign io_awid    = '0;

  // wlast comes from our own beat count, so the client never has to supply it.
  assign io_wdata  = wr_wdata;
  assign io_wstrb  = wr_wstrb;
  assign io_wvalid = (wr_state == W_DATA) & wr_wvalid;
  assign wr_wready = (wr_state == W_DATA) & io_wready;
  assign io_wlast  = (wr_state == W_DATA) & (wcnt == aw_q.len);
  assign io_bready = (wr_state == W_RESP);

  // No error path and a single outstanding burst per channel: responses and ids carry no information.
  logic unused_ok;
  assign unused_ok = ^{io_rresp, io_rid, io_bresp, io_bid, arb_grant};

endmodule

// File: tb/tb_axi_mem_arbiter.sv
module tb_axi_mem_arbiter;
  import axi_pkg::*;

  logic        clock;
  logic        reset;
  logic [1:0]  rd_req_valid, rd_req_ready;
  logic [63:0] rd_req_addr;
  logic [15:0] rd_req_len;
  logic [5:0]  rd_req_size;
  logic [1:0]  rd_rvalid, rd_rlast, rd_rready;
  logic [31:0] rd_rdata;
  logic        wr_req_valid, wr_req_ready;
  logic [31:0] wr_req_addr;
  logic [7:0]  wr_req_len;
  logic [2:0]  wr_req_size;
  logic [31:0] wr_wdata;
  logic [3:0]  wr_wstrb;
  logic        wr_wvalid, wr_wready, wr_done;
  logic [31:0] io_araddr;
  logic [7:0]  io_arlen;
  logic [2:0]  io_arsize;
  logic [1:0]  io_arburst;
  logic [3:0]  io_arid;
  logic        io_arvalid, io_arready;
  logic [31:0] io_rdata;
  logic [1:0]  io_rresp;
  logic        io_rlast;
  logic [3:0]  io_rid;
  logic        io_rvalid, io_rready;
  logic [31:0] io_awaddr;
  logic [7:0]  io_awlen;
  logic [2:0]  io_awsize;
  logic [1:0]  io_awburst;
  logic [3:0]  io_awid;
  logic        io_awvalid, io_awready;
  logic [31:0] io_wdata;
  logic [3:0]  io_wstrb;
  logic        io_wlast, io_wvalid, io_wready;
  logic [1:0]  io_bresp;
  logic [3:0]  io_bid;
  logic        io_bvalid, io_bready;

  int tests = 0;
  int fails = 0;

  axi_mem_arbiter #(.N_RD(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_req_len(rd_req_len), .rd_req_size(rd_req_size), .rd_rvalid(rd_rvalid),
    .rd_rlast(rd_rlast), .rd_rready(rd_rready), .rd_rdata(rd_rdata),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
    .wr_req_len(wr_req_len), .wr_req_size(wr_req_size), .wr_wdata(wr_wdata),
    .wr_wstrb(wr_wstrb), .wr_wvalid(wr_wvalid), .wr_wready(wr_wready), .wr_done(wr_done),
    .io_araddr(io_araddr), .io_arlen(io_arlen), .io_arsize(io_arsize), .io_arburst(io_arburst),
    .io_arid(io_arid), .io_arvalid(io_arvalid), .io_arready(io_arready),
    .io_rdata(io_rdata), .io_rresp(io_rresp), .io_rlast(io_rlast), .io_rid(io_rid),
    .io_rvalid(io_rvalid), .io_rready(io_rready),
    .io_awaddr(io_awaddr), .io_awlen(io_awlen), .io_awsize(io_awsize), .io_awburst(io_awburst),
    .io_awid(io_awid), .io_awvalid(io_awvalid), .io_awready(io_awready),
    .io_wdata(io_wdata), .io_wstrb(io_wstrb), .io_wlast(io_wlast), .io_wvalid(io_wvalid),
    .io_wready(io_wready),
    .io_bresp(io_bresp), .io_bid(io_bid), .io_bvalid(io_bvalid), .io_bready(io_bready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [1:0]  req;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [7:0]  len0;
    logic [7:0]  len1;
    int          ar_delay;
    int          stall_beat;
    int          stall_cycles;
    int          exp_id;
    logic [31:0] exp_addr;
    logic [7:0]  exp_len;
  } rd_vec_t;

  rd_vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // One read burst through the arbiter with a bench-side AXI slave.
  task automatic run_read(input rd_vec_t v, input int tag);
    logic [1:0] oh;
    int bad, got, b, stall_left, stall_seen, guard;
    oh = 2'b01 << v.exp_id;
    rd_req_valid = v.req;
    rd_req_addr  = {v.addr1, v.addr0};
    rd_req_len   = {v.len1, v.len0};
    rd_req_size  = {3'd2, 3'd2};
    rd_rready    = 2'b11;
    io_arready   = 1'b0;
    cyc();
    #1;
    check("ar_valid", io_arvalid, 1);
    check("ar_id", io_arid, v.exp_id);
    check("ar_addr", io_araddr, v.exp_addr);
    check("ar_len", io_arlen, v.exp_len);
    check("ar_burst_size", {io_arburst, io_arsize}, {2'b01, 3'd2});
    bad = 0;
    for (int d = 0; d < v.ar_delay; d++) begin
      cyc();
      #1;
      if (io_arvalid !== 1'b1 || io_araddr !== v.exp_addr || rd_req_ready !== 2'b00) bad++;
    end
    check("ar_hold", bad, 0);
    io_arready = 1'b1;
    #1;
    check("req_ready", rd_req_ready, oh);
    cyc();
    io_arready   = 1'b0;
    rd_req_valid = v.req & ~oh;

    b = 0; got = 0; bad = 0; stall_left = v.stall_cycles; stall_seen = 0; guard = 0;
    while (b <= int'(v.exp_len) && guard < 64) begin
      io_rvalid = 1'b1;
      io_rdata  = 32'hD000_0000 + tag * 256 + b;
      io_rlast  = (b == int'(v.exp_len));
      rd_rready = (b == v.stall_beat && stall_left > 0) ? (2'b11 & ~oh) : 2'b11;
      #1;
      if (rd_rvalid !== oh || rd_rdata !== io_rdata || io_rready !== |(rd_rready & oh)) bad++;
      if (rd_rlast !== (io_rlast ? oh : 2'b00)) bad++;
      if (io_rready === 1'b1) begin
        got++;
        b++;
      end else begin
        stall_seen++;
        if (stall_left > 0) stall_left--;
      end
      cyc();
      guard++;
    end
    #1;
    check("r_beats", got, v.exp_len + 1);
    check("r_errs", bad, 0);
    check("r_stall", stall_seen, v.stall_cycles);
    check("rd_idle", dut.rd_state, R_IDLE);
    check("r_gate_idle", {rd_rvalid, io_rready}, 3'b000);
    io_rvalid = 1'b0;
    io_rlast  = 1'b0;
  endtask

  // One write burst; toggle makes wr_wvalid alternate 1,0,1,0...
  task automatic run_write(input logic [31:0] addr, input logic [7:0] len, input bit toggle,
                           input int b_delay);
    int beats, wl_cnt, bad, cyc_n;
    logic wv;
    wr_req_addr  = addr;
    wr_req_len   = len;
    wr_req_size  = 3'd2;
    wr_req_valid = 1'b1;
    #1;
    check("wr_req_ready_idle", wr_req_ready, 1);
    cyc();
    wr_req_valid = 1'b0;
    #1;
    check("aw_valid", io_awvalid, 1);
    check("aw_addr", io_awaddr, addr);
    check("aw_len", io_awlen, len);
    check("aw_id_burst", {io_awid, io_awburst}, {4'd0, 2'b01});
    io_awready = 1'b1;
    cyc();
    io_awready = 1'b0;
    beats = 0; wl_cnt = 0; bad = 0; cyc_n = 0;
    while (beats <= int'(len) && cyc_n < 64) begin
      wv        = toggle ? (cyc_n % 2 == 0) : 1'b1;
      wr_wvalid = wv;
      wr_wdata  = 32'hA500_0000 + beats;
      wr_wstrb  = 4'hF;
      io_wready = 1'b1;
      #1;
      if (io_wvalid !== wv || wr_wready !== 1'b1 || io_wdata !== wr_wdata || io_wstrb !== 4'hF) bad++;
      if (io_wlast !== (beats == int'(len))) bad++;
      if (wv) begin
        if (io_wlast === 1'b1) wl_cnt++;
        beats++;
      end
      cyc();
      cyc_n++;
    end
    check("w_beats", beats, len + 1);
    check("w_last_count", wl_cnt, 1);
    check("w_passthru", bad, 0);
    wr_wvalid = 1'b1;
    #1;
    check("w_resp_gate", {io_bready, io_wvalid}, 2'b10);
    bad = 0;
    for (int d = 0; d < b_delay; d++) begin
      cyc();
      #1;
      if (wr_done !== 1'b0 || io_bready !== 1'b1) bad++;
    end
    check("b_wait", bad, 0);
    wr_wvalid = 1'b0;
    io_bvalid = 1'b1;
    #1;
    check("done_early", wr_done, 0);
    cyc();
    io_bvalid = 1'b0;
    #1;
    check("wr_done", {wr_done, wr_req_ready}, 2'b11);
    cyc();
    check("done_pulse", wr_done, 0);
  endtask

  rd_vec_t cv;

  initial begin
    reset = 1'b1;
    rd_req_valid = '0; rd_req_addr = '0; rd_req_len = '0; rd_req_size = '0; rd_rready = '0;
    wr_req_valid = 0; wr_req_addr = '0; wr_req_len = '0; wr_req_size = '0;
    wr_wdata = '0; wr_wstrb = '0; wr_wvalid = 0;
    io_arready = 0; io_rdata = '0; io_rresp = '0; io_rlast = 0; io_rid = '0; io_rvalid = 0;
    io_awready = 0; io_wready = 0; io_bresp = '0; io_bid = '0; io_bvalid = 0;

    //            req    addr0         addr1         len0  len1  dly stb stc id exp_addr      exp_len
    vecs[0] = '{2'b01, 32'h1C00_0000, 32'h0,        8'd3, 8'd0, 2,  0,  0,  0, 32'h1C00_0000, 8'd3};
    vecs[1] = '{2'b10, 32'h0,        32'h1C00_0040, 8'd0, 8'd1, 0,  0,  0,  1, 32'h1C00_0040, 8'd1};
    vecs[2] = '{2'b01, 32'h1C00_0080, 32'h0,        8'd0, 8'd0, 1,  0,  0,  0, 32'h1C00_0080, 8'd0};
    vecs[3] = '{2'b10, 32'h0,        32'h2000_0000, 8'd0, 8'd3, 0,  1,  3,  1, 32'h2000_0000, 8'd3};
    vecs[4] = '{2'b11, 32'h3000_0000, 32'h3000_1000, 8'd1, 8'd2, 0,  0,  0,  0, 32'h3000_0000, 8'd1};
`ifdef AXI_ARB_RR_EN
    vecs[5] = '{2'b11, 32'h3000_0000, 32'h3000_1000, 8'd1, 8'd2, 0,  0,  0,  1, 32'h3000_1000, 8'd2};
    vecs[6] = '{2'b01, 32'h3000_0000, 32'h3000_1000, 8'd1, 8'd2, 0,  0,  0,  0, 32'h3000_0000, 8'd1};
`else
    vecs[5] = '{2'b11, 32'h3000_0000, 32'h3000_1000, 8'd1, 8'd2, 0,  0,  0,  0, 32'h3000_0000, 8'd1};
    vecs[6] = '{2'b10, 32'h3000_0000, 32'h3000_1000, 8'd1, 8'd2, 0,  0,  0,  1, 32'h3000_1000, 8'd2};
`endif

    repeat (3) cyc();
    reset = 1'b0;
    #1;
    check("rst_valids", {io_arvalid, io_awvalid, io_wvalid, io_rready, io_bready}, 5'b0);
    check("rst_rd_out", {rd_req_ready, rd_rvalid, rd_rlast, rd_rdata}, 38'h0);
    check("rst_wr", {wr_done, wr_req_ready}, 2'b01);
    check("rst_ar_regs", {io_araddr, io_arlen, io_arsize, io_arid}, 47'h0);
    check("rst_aw_regs", {io_awaddr, io_awlen, io_awsize}, 43'h0);
    check("rst_wcnt", dut.wcnt, 0);

    for (int i = 0; i < 7; i++) begin
      run_read(vecs[i], i);
    end

    run_write(32'h1C00_0100, 8'd7, 1'b1, 2);

    cv = '{2'b01, 32'h1C00_0200, 32'h0, 8'd3, 8'd0, 1, 0, 0, 0, 32'h1C00_0200, 8'd3};
    fork
      run_read(cv, 9);
      run_write(32'h1C00_0300, 8'd0, 1'b0, 0);
    join
    cyc();

    // Reset in the middle of a read and a write burst.
    rd_req_valid = 2'b01; rd_req_addr = {32'h0, 32'h1C00_0400}; rd_req_len = {8'd0, 8'd3};
    wr_req_valid = 1'b1; wr_req_addr = 32'h1C00_0500; wr_req_len = 8'd3;
    cyc();
    io_arready = 1'b1; io_awready = 1'b1; rd_req_valid = '0; wr_req_valid = 1'b0;
    cyc();
    io_arready = 1'b0; io_awready = 1'b0;
    io_rvalid = 1'b1; io_rlast = 1'b0; io_rdata = 32'h5555_0000; rd_rready = 2'b11;
    wr_wvalid = 1'b1; io_wready = 1'b1;
    #1;
    check("rst_pre_r", rd_rvalid, 2'b01);
    cyc();
    check("rst_pre_wcnt", dut.wcnt, 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    check("mid_rst_valids", {io_arvalid, io_awvalid, io_wvalid, io_rready, io_bready, rd_rvalid}, 7'b0);
    check("mid_rst_fsm", {dut.rd_state, dut.wr_state}, {R_IDLE, W_IDLE});
    check("mid_rst_wcnt", dut.wcnt, 0);
    check("mid_rst_ready", {wr_req_ready, wr_done}, 2'b10);
    io_rvalid = 1'b0; wr_wvalid = 1'b0; io_wready = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi_mem_arbiter.md
# axi_mem_arbiter

Shares the single AXI4 port of `main_memory` between N cache read clients and one write-back client. It sits between the CPU's cache miss/refill logic and the top-level AXI bus (`io_ar*`, `io_r*`, `io_aw*`, `io_w*`, `io_b*`). Read and write channels are sequenced independently. Reads use a one-outstanding-burst arbiter; writes use a single-client burst FSM that generates `wlast` itself.

## Interface
Parameters:
- `N_RD`, 2, number of read clients (client 0 = ICache, client 1 = DCache)
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width

Ports (`clock` and `reset`: one clock; reset is synchronous and active-high):
- `clock`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `rd_req_valid`  in  N_RD  per-client read request
- `rd_req_ready`  out  N_RD  one-hot pulse on the cycle that client's AR handshake completes
- `rd_req_addr`  in  N_RD*ADDR_W  packed burst start addresses
- `rd_req_len`  in  N_RD*8  packed AXI len (beats-1)
- `rd_req_size`  in  N_RD*3  packed AXI size
- `rd_rvalid`, `rd_rlast`  out  N_RD  per-client beat valid and last, one-hot
- `rd_rready`  in  N_RD  per-client beat accept
- `rd_rdata`  out  DATA_W  shared read data, meaningful only with `rd_rvalid`
- `wr_req_valid` / `wr_req_ready`  in/out  1  write burst request and accept
- `wr_req_addr` / `wr_req_len` / `wr_req_size`  in  ADDR_W/8/3  write burst descriptor
- `wr_wdata` / `wr_wstrb`  in  DATA_W/4  write beat data and strobes
- `wr_wvalid` / `wr_wready`  in/out  1  write beat handshake
- `wr_done`  out  1  one-cycle pulse on B handshake
- `io_*`  AXI4 master: ar{addr,len,size,burst,id,valid,ready}, r{data,resp,last,id,valid,ready}, aw{…}, w{data,strb,last,valid,ready}, b{resp,id,valid,ready}; ids are 4 bits

## Operation
- Read FSM states: `R_IDLE`, `R_ADDR`, `R_DATA`.
- `R_IDLE`: if any `rd_req_valid` is set, pick a winner, latch its index, addr, len and size, then go to `R_ADDR`.
- `R_ADDR`: drive `io_arvalid=1`, `io_arid`=index, `io_arburst`=INCR (2'b01). On `io_arready`, pulse `rd_req_ready[idx]` and go to `R_DATA`.
- `R_DATA`:
  - `rd_rvalid[idx]=io_rvalid` and `io_rready=rd_rready[idx]`; all other clients see 0.
  - On `io_rvalid&io_rready&io_rlast`, return to `R_IDLE`.
- Write FSM states: `W_IDLE`, `W_ADDR`, `W_DATA`, `W_RESP`.
- `W_IDLE`: `wr_req_ready=1`. On `wr_req_valid`, latch the descriptor, clear beat counter `wcnt` (8 bits), go to `W_ADDR`.
- `W_ADDR`: drive `io_awvalid`, INCR burst, `io_awid`=0. On `io_awready`, go to `W_DATA`.
- `W_DATA`:
  - `io_wvalid=wr_wvalid`, `wr_wready=io_wready`, `io_wlast=(wcnt==len)`.
  - Each W handshake increments `wcnt`; the handshake with `wlast` goes to `W_RESP`.
- `W_RESP`: `io_bready=1`. On `io_bvalid`, pulse `wr_done` and go to `W_IDLE`.
- Read and write FSMs are independent and may be active simultaneously.
- `io_rresp` and `io_bresp` are ignored (no error path).

## Timing
- Reset values:
  - all FSMs idle; `io_arvalid`, `io_awvalid`, `io_wvalid`, `io_rready`, `io_bready` = 0
  - all `rd_*` outputs = 0, `wr_done` = 0
  - RR pointer = 0, `wcnt` = 0
  - AR/AW address, len, size, id registers = 0
- Request to `io_arvalid`: 1 cycle (arbitrate in `R_IDLE`, AR registered). Same for write request to `io_awvalid`.
- `io_arvalid` and `io_awvalid` are held with stable payload until ready; they are never withdrawn.
- `rd_rdata`, `rd_rvalid`, `io_rready`, and the W-channel signals are combinational pass-through (0 added latency).
- A new grant is possible in the cycle after the last R beat, so back-to-back bursts have ≥1 idle cycle.
- `len=0`: `io_wlast` is asserted on the first beat.
- A request that drops `valid` before grant is not served. A request must stay asserted until `rd_req_ready`.
- `reset` mid-burst aborts immediately to reset state. The memory must also be reset (same `reset`).

## Configuration
- `AXI_ARB_RR_EN` defined: round-robin arbitration. The pointer moves to winner+1 (mod N_RD) at each grant; search starts at the pointer.
- `AXI_ARB_RR_EN` undefined: fixed priority, lowest index wins. The RR pointer is not instantiated.

## Structure
- Package `axi_pkg`:
  - `BURST_INCR`, `ID_W=4`
  - state enums `rd_state_t`, `wr_state_t`
  - struct `axi_req_t` {addr,len,size}
- Sub-module `rr_arbiter` (N-way, one-hot grant, pointer under `AXI_ARB_RR_EN`), instantiated once for the read side.

## Test plan
- Single ICache read, addr 0x1C000000, len 3, arready delayed 2 cycles → `io_araddr` stable; 4 beats reach client 0 only; `rd_rlast[0]` on beat 4; FSM back to `R_IDLE`.
- Both clients request in the same cycle, RR enabled, twice → grants go 0 then 1 (`io_arid` 0 then 1). With the macro undefined, client 0 wins both times.
- Write 0x1C000100, len 7, `wr_wvalid` toggling every cycle → exactly 8 W beats; `io_wlast` only on the 8th; `wr_done` one cycle after `io_bvalid`.
- Read burst len 3 concurrent with write burst len 0 → both complete; no cross-talk between R and W signals.
- Client deasserts `rd_rready` for 3 cycles mid-burst → `io_rready`=0 during that window; no beat lost or duplicated.
- `reset` asserted in `R_DATA` and `W_DATA` → the next cycle shows all valids 0, FSMs idle, `wcnt`=0.
